// File: rtl/pad_owner_arbiter.sv
// pad_owner_arbiter
//   Arbitrates per-pad ownership of the user GPIO pads between the SoC core
//   and the management processor (Wishbone slave). An ownership change holds
//   the switching pads tri-stated for GUARD_CYCLES before the new owner
//   drives them, so two drivers never fight on a pad.
// Ports
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   wbs_*                      Wishbone classic slave (256-byte window at BASE_ADDR)
//   core_out_i / core_oeb_i    core per-pad output value / enable (active-low)
//   io_in                      pad inputs (only synchronized for PAD_IN reads)
//   io_out / io_oeb            registered pad drive / enable (active-low)
//   irq_o                      switch-complete interrupt, level, W1C in STATUS
// GUARD_CYCLES must fit the 8-bit STATUS counter field (1..255).
module pad_owner_arbiter #(
  parameter int          NPADS        = 38,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPADS-1:0] core_out_i,
  input  logic [NPADS-1:0] core_oeb_i,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic             irq_o
);

  localparam logic [7:0] GC = 8'(GUARD_CYCLES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GUARD = 2'd1, S_COMMIT = 2'd2} state_e;

  state_e           state_q;
  logic [NPADS-1:0] owner_q, pend_q, chg_q;
  logic [NPADS-1:0] mg_out_q, mg_oeb_q, sync1_q, sync2_q;
  logic [7:0]       cnt_q;
  logic             irq_q, ack_q;
  logic [31:0]      dat_q;

  // Byte-masked write of one 32-bit word into a 64-bit (LO/HI) register pair.
  function automatic logic [63:0] wmerge(input logic [63:0] old, input logic hi,
                                         input logic [31:0] d, input logic [3:0] sel);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[(hi ? 32 : 0) + 8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- Wishbone decode ----------------
  logic [5:0] off;
  logic       hit, req, busy, is_own, stall, acc, wr, own_wr, irq_clr;
  assign off    = wbs_adr_i[7:2];
  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req    = wbs_stb_i & wbs_cyc_i & hit;
  assign busy   = (state_q != S_IDLE);
  assign is_own = (off == 6'd0) || (off == 6'd1);
  // OWNER writes wait for the FSM to go idle; everything else proceeds.
  assign stall  = wbs_we_i & is_own & busy;
  // ~ack_q forces a gap so a held request is never acked twice in a row.
  assign acc    = req & ~ack_q & ~stall;
  assign wr     = acc & wbs_we_i;
  assign own_wr = wr & is_own;
  assign irq_clr = wr & (off == 6'd8) & wbs_sel_i[0] & wbs_dat_i[1];

  logic [63:0] own64, mgo64, mge64, pin64, own_m, mgo_m, mge_m;
  assign own64 = 64'(owner_q);
  assign mgo64 = 64'(mg_out_q);
  assign mge64 = 64'(mg_oeb_q);
  assign pin64 = 64'(sync2_q);
  assign own_m = wmerge(own64, off[0], wbs_dat_i, wbs_sel_i);
  assign mgo_m = wmerge(mgo64, off[0], wbs_dat_i, wbs_sel_i);
  assign mge_m = wmerge(mge64, off[0], wbs_dat_i, wbs_sel_i);

  logic [NPADS-1:0] own_new, own_chg;
  assign own_new = own_m[NPADS-1:0];
  assign own_chg = own_new ^ owner_q;

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (off)
      6'd0:    rdata = own64[31:0];
      6'd1:    rdata = own64[63:32];
      6'd2:    rdata = mgo64[31:0];
      6'd3:    rdata = mgo64[63:32];
      6'd4:    rdata = mge64[31:0];
      6'd5:    rdata = mge64[63:32];
      6'd6:    rdata = pin64[31:0];
      6'd7:    rdata = pin64[63:32];
      6'd8:    rdata = {16'h0, cnt_q, 6'h0, irq_q, busy};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      mg_out_q <= '0;
      mg_oeb_q <= '1;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      ack_q   <= acc;
      dat_q   <= (acc & ~wbs_we_i) ? rdata : '0;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      if (wr && off[5:1] == 5'd1) mg_out_q <= mgo_m[NPADS-1:0];
      if (wr && off[5:1] == 5'd2) mg_oeb_q <= mge_m[NPADS-1:0];
    end
  end

  // ---------------- Switch FSM ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      pend_q  <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      // COMMIT sets irq even if software clears it in the same cycle.
      irq_q <= (state_q == S_COMMIT) | (irq_q & ~irq_clr);
      case (state_q)
        S_IDLE: begin
          if (own_wr) begin
            if (own_chg == '0) begin
              owner_q <= own_new;
            end else begin
              pend_q  <= own_new;
              chg_q   <= own_chg;
              cnt_q   <= GC;
              state_q <= S_GUARD;
            end
          end
        end
        S_GUARD: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          owner_q <= pend_q;
          chg_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- Pad mux ----------------
  // In COMMIT the new owner is already used so the pad goes straight from
  // tri-state to its new driver, never briefly back to the old one.
  logic [NPADS-1:0] guard, eff;
  assign guard = (state_q == S_GUARD) ? chg_q : '0;
  assign eff   = (state_q == S_COMMIT) ? pend_q : owner_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      io_out <= '0;
      io_oeb <= '1;
    end else begin
      io_out <= ~guard & ((eff & mg_out_q) | (~eff & core_out_i));
      io_oeb <= guard | (eff & mg_oeb_q) | (~eff & core_oeb_i);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  logic unused_ok;
  assign unused_ok = ^wbs_adr_i[1:0];

endmodule

// File: tb/tb_pad_owner_arbiter.sv
module tb_pad_owner_arbiter;
  localparam int NPADS = 38;
  localparam int GUARD = 4;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [31:0] OWN_LO = B + 32'h00, MGO_LO = B + 32'h08, MGO_HI = B + 32'h0C;
  localparam logic [31:0] MGE_LO = B + 32'h10, MGE_HI = B + 32'h14, PIN_LO = B + 32'h18;
  localparam logic [31:0] STAT = B + 32'h20;

  logic clk = 1'b0, rst_n;
  logic stb, cyc, we, ack, irq;
  logic [3:0] sel;
  logic [31:0] adr, wdat, rdat;
  logic [NPADS-1:0] core_out, core_oeb, io_in, io_out, io_oeb;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  pad_owner_arbiter #(.NPADS(NPADS), .GUARD_CYCLES(GUARD), .BASE_ADDR(B)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_out_i(core_out), .core_oeb_i(core_oeb), .io_in(io_in),
    .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one access from the current (negedge) time; returns at the
  // negedge where ack was seen, or after a 20-cycle bound.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic acked, output logic [31:0] rd,
                     output int waited);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; rd = '0; waited = 0;
    while (!acked && waited < 20) begin
      @(negedge clk);
      waited++;
      if (ack) begin acked = 1'b1; rd = rdat; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic ak; logic [31:0] rd; int wt;
    bus(1'b1, a, d, s, ak, rd, wt);
    check({tag, "_ack"}, 64'(ak), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic ak; logic [31:0] rd; int wt;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus(1'b0, a, 32'h0, 4'hF, ak, rd, wt);
    check({tag, "_ack"}, 64'(ak), 64'd1);
    if (ak) check(tag_q.pop_front(), 64'(rd), 64'(exp_q.pop_front()));
    else begin void'(tag_q.pop_front()); void'(exp_q.pop_front()); end
  endtask

  initial begin
    logic ak; logic [31:0] rd; int wt;
    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    core_out = '1; core_oeb = '0; io_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_io_out", 64'(io_out), 64'd0);
    check("rst_io_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("core_out", 64'(io_out), 64'({NPADS{1'b1}}));
    check("core_oeb", 64'(io_oeb), 64'd0);
    rd_chk("rst_owner", OWN_LO, 32'h0);
    rd_chk("rst_mge_lo", MGE_LO, 32'hFFFF_FFFF);
    rd_chk("rst_mge_hi", MGE_HI, 32'h0000_003F);
    rd_chk("rst_status", STAT, 32'h0);
    wr("mgo_hi_w", MGO_HI, 32'hFFFF_FFFF, 4'hF);
    rd_chk("mgo_hi_r", MGO_HI, 32'h0000_003F);

    // Pad 0 to management with guard interval
    wr("mgo_lo_w", MGO_LO, 32'h0, 4'hF);
    wr("mge_lo_w", MGE_LO, 32'h0, 4'hF);
    wr("own1_w", OWN_LO, 32'h1, 4'hF);
    check("pre_guard_oeb0", 64'(io_oeb[0]), 64'd0);
    for (int c = 0; c < GUARD; c++) begin
      @(negedge clk);
      check("guard_oeb0", 64'(io_oeb[0]), 64'd1);
      check("guard_out0", 64'(io_out[0]), 64'd0);
      check("guard_others_out", 64'(io_out[NPADS-1:1]), 64'({(NPADS-1){1'b1}}));
      check("guard_others_oeb", 64'(io_oeb[NPADS-1:1]), 64'd0);
    end
    @(negedge clk);
    check("mg_oeb0", 64'(io_oeb[0]), 64'd0);
    check("mg_out0", 64'(io_out[0]), 64'd0);
    check("irq_set", 64'(irq), 64'd1);
    rd_chk("status_irq", STAT, 32'h2);
    @(negedge clk);
    check("ack_pulse", 64'(ack), 64'd0);
    check("dat_idle", 64'(rdat), 64'd0);

    // Held request: ack, gap, ack
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = OWN_LO; sel = 4'hF;
    @(negedge clk); check("held_ack0", 64'(ack), 64'd1);
    @(negedge clk); check("held_ack1", 64'(ack), 64'd0);
    @(negedge clk); check("held_ack2", 64'(ack), 64'd1);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);

    // Clear irq, then stalled OWNER write
    wr("clr1", STAT, 32'h2, 4'hF);
    check("irq_clr1", 64'(irq), 64'd0);
    wr("own3_w", OWN_LO, 32'h3, 4'hF);
    bus(1'b1, OWN_LO, 32'h2, 4'hF, ak, rd, wt);
    check("stall_ack", 64'(ak), 64'd1);
    check("stall_delayed", 64'(wt > GUARD), 64'd1);
    check("stall_irq", 64'(irq), 64'd1);
    check("pad1_mg_oeb", 64'(io_oeb[1]), 64'd0);
    check("pad1_mg_out", 64'(io_out[1]), 64'd0);
    for (int c = 0; c < GUARD; c++) begin
      @(negedge clk);
      check("g2_oeb0", 64'(io_oeb[0]), 64'd1);
      check("g2_pad1", 64'({io_out[1], io_oeb[1]}), 64'd0);
    end
    @(negedge clk);
    check("pad0_core", 64'({io_out[0], io_oeb[0]}), 64'b10);
    rd_chk("own_after", OWN_LO, 32'h2);

    // Clear coinciding with COMMIT
    wr("clr2", STAT, 32'h2, 4'hF);
    check("irq_clr2", 64'(irq), 64'd0);
    wr("own6_w", OWN_LO, 32'h6, 4'hF);
    repeat (GUARD) @(negedge clk);
    wr("clr_commit", STAT, 32'h2, 4'hF);
    check("irq_set_wins", 64'(irq), 64'd1);
    wr("clr3", STAT, 32'h2, 4'hF);
    check("irq_clr3", 64'(irq), 64'd0);

    // Synchronizer, byte enables, holes, out-of-window
    io_in[7:0] = 8'h5A;
    repeat (2) @(negedge clk);
    rd_chk("pad_in", PIN_LO, 32'h5A);
    wr("mgo_full", MGO_LO, 32'h1234_5678, 4'hF);
    wr("mgo_byte", MGO_LO, 32'hAABB_CCDD, 4'b0010);
    rd_chk("mgo_merge", MGO_LO, 32'h1234_CC78);
    rd_chk("hole_0x40", B + 32'h40, 32'h0);
    bus(1'b0, 32'h3000_1000, 32'h0, 4'hF, ak, rd, wt);
    check("no_ack_outside", 64'(ak), 64'd0);

    // Reset during GUARD
    wr("own0_w", OWN_LO, 32'h0, 4'hF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
    check("abort_out", 64'(io_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_oeb", 64'(io_oeb), 64'd0);
    rd_chk("post_rst_owner", OWN_LO, 32'h0);
    rd_chk("post_rst_status", STAT, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pad_owner_arbiter.md
Name: pad_owner_arbiter

Overview:
Arbitrates ownership of the user-area GPIO pads between the SoC core (ChipTop peripheral pins) and the management processor over the Wishbone slave port. Each pad has an owner bit. Ownership changes are sequenced through a tri-state guard interval so two drivers never contend on a pad. Sits between ChipTop's pin-level signals and the io_out/io_oeb/io_in pad bus in the user project wrapper.

Parameters:
NPADS, 38, number of pads arbitrated (33..64)
GUARD_CYCLES, 4, cycles a switching pad is held tri-stated before the new owner drives it (>=1)
BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes BASE_ADDR[31:8]

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
core_out_i  in  NPADS  ChipTop per-pad output value
core_oeb_i  in  NPADS  ChipTop per-pad output enable, active-low
io_in  in  NPADS  pad input
io_out  out  NPADS  pad output, registered
io_oeb  out  NPADS  pad output enable, active-low, registered
irq_o  out  1  switch-complete interrupt, level

Behaviour:
- Reset values: io_out=0, io_oeb=all 1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, OWNER=0 (all pads owned by core), MG_OUT=0, MG_OEB=all 1, FSM=IDLE, guard counter=0.
- Register map, word offsets; HI registers implement bits [NPADS-33:0], unimplemented bits read 0:
  0x00/0x04 OWNER_LO/HI, RW. 1 = management owns the pad.
  0x08/0x0C MG_OUT_LO/HI, RW.
  0x10/0x14 MG_OEB_LO/HI, RW.
  0x18/0x1C PAD_IN_LO/HI, RO. io_in passed through a 2-flop synchronizer.
  0x20 STATUS: bit0 busy (RO), bit1 irq (W1C), bits[15:8] guard counter (RO).
  Other offsets inside the 256-byte window: read 0, writes ignored, still acked.
- Wishbone classic cycle: a request is stb&cyc with adr[31:8]==BASE_ADDR[31:8]. Requests outside the window get no ack.
  - Non-stalled access: wbs_ack_o is a 1-cycle pulse on the cycle after the request. Read data is valid with ack; wbs_dat_o returns 0 when ack is low.
  - A held request is not acked twice: ack is deasserted for at least one cycle between accesses.
  - wbs_sel_i masks writes per byte.
- Pad mux, registered with 1-cycle latency. Per pad, using the effective owner:
  - Pad in GUARD: io_oeb=1, io_out=0.
  - Effective owner = core: {io_out,io_oeb} <= {core_out_i,core_oeb_i}.
  - Effective owner = management: {io_out,io_oeb} <= {MG_OUT,MG_OEB}.
- Switch FSM: IDLE -> GUARD -> COMMIT -> IDLE.
  - IDLE: a write to OWNER_LO/HI computes new = merged write value and chg = new ^ OWNER.
    - chg==0: OWNER is written, no state change.
    - chg!=0: latch pending=new, chg_mask=chg, counter=GUARD_CYCLES, go to GUARD. The write is acked normally.
  - GUARD: pads in chg_mask are tri-stated; other pads are unaffected. Counter decrements each cycle; at 1, go to COMMIT.
  - COMMIT, one cycle: OWNER<=pending, chg_mask<=0, irq<=1, go to IDLE.
  - busy=1 in GUARD and COMMIT.
- An OWNER write while busy is stalled: ack is withheld until the FSM returns to IDLE, and the write is then processed as in IDLE. Writes to other registers and all reads are never stalled.
- If a STATUS irq clear and COMMIT occur in the same cycle, set wins and irq stays 1.
- Asserting reset mid-GUARD aborts the switch: all outputs and registers take their reset values immediately (asynchronously).
- io_in is not gated by this block; ChipTop taps it directly.

Test Plan:
- Reset, then core_out_i=all 1, core_oeb_i=0 -> one cycle later io_out=all 1, io_oeb=0; during reset io_oeb=all 1 and io_out=0.
- Write OWNER_LO=0x1, MG_OUT_LO=0x0, MG_OEB_LO=0x0, with GUARD_CYCLES=4 -> pad0 shows io_oeb=1 for 4 cycles, then io_out[0]=0 and io_oeb[0]=0; irq_o=1; STATUS reads 0x2; other pads follow the core throughout.
- Write OWNER_LO=0x2 while busy -> ack delayed until after COMMIT; pad0 returns to the core and pad1 goes to management, each after its own guard interval.
- Write STATUS=0x2 in the same cycle as COMMIT -> irq_o stays 1; a subsequent clear -> irq_o=0.
- Drive io_in=0x5A on pads 7:0 -> PAD_IN_LO reads 0x5A within 3 cycles; a byte write with sel=4'b0010 to MG_OUT_LO changes only bits [15:8]; a read from offset 0x40 returns 0 with ack; an access with adr=0x3000_1000 gets no ack.
- Assert wb_rst_ni low during GUARD -> io_oeb=all 1 immediately, OWNER=0, busy=0 after release.
